dqm_framer: RTL and testbench

Parametrised DQM frame serializer and successor to the fixed 3-word/64-bit DQM output stage. Buffers an incoming decoded bit stream in an internal FIFO. Emits MSB-first frames of a configurable header (HDR_WORDS words of WORD_W bits, plus an optional frame-count word) followed by exactly `block_size` payload bits. A frame only starts once a full payload is buffered, so a frame never underflows mid-payload. Sits between the decoder output and the serial DQM/telemetry output, in the single `clk` domain.

---
 rtl/dqm_framer.sv | 239 +++++++++++++++++++++++
 tb/tb_dqm_framer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dqm_framer.sv
// DQM frame serializer: buffers payload bits in a FIFO and emits MSB-first header+payload frames.
// Optional macro DQM_FRAME_COUNT_EN appends a frame-count word after the staged header words.
module dqm_framer #(
    parameter int WORD_W     = 16,
    parameter int HDR_WORDS  = 3,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    input  logic [HDR_WORDS*WORD_W-1:0]   hdr_words,
    input  logic                          hdr_load,
    input  logic [CNT_W-1:0]              block_size,
    input  logic                          enable,
    input  logic                          clear_overflow,
    output logic                          serial_out,
    output logic                          serial_valid,
    output logic                          interrupt,
    output logic [CNT_W-1:0]              frame_cnt,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int STG_W = HDR_WORDS * WORD_W;
`ifdef DQM_FRAME_COUNT_EN
    localparam int HDR_BITS = STG_W + WORD_W;
`else
    localparam int HDR_BITS = STG_W;
`endif
    localparam int HB_W  = $clog2(HDR_BITS + 1);
    localparam int CW    = (CNT_W > HB_W) ? CNT_W : HB_W;
    localparam int CMP_W = ((CNT_W > LVL_W) ? CNT_W : LVL_W) + 1;
    localparam logic [CW-1:0]    HDR_LAST = CW'(HDR_BITS - 1);
    localparam logic [CMP_W-1:0] DEPTH_C  = CMP_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [FIFO_DEPTH-1:0] r_mem;
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [LVL_W-1:0]      r_level;
    logic [STG_W-1:0]      r_stage;
    logic [HDR_BITS-1:0]   r_shift;
    logic [CW-1:0]         r_bit_cnt;
    logic [CNT_W-1:0]      r_blk;
    logic [CNT_W-1:0]      r_frame_cnt;
    logic                  r_overflow;
    logic                  r_serial_out;
    logic                  r_serial_valid;
    logic                  r_interrupt;

    logic                  w_rd;
    logic                  w_rd_bit;
    logic                  w_full;
    logic                  w_wr;
    logic                  w_drop;
    logic [LVL_W-1:0]      w_lvl_eval;
    logic                  w_bs_ok;
    logic                  w_start_ok;
    logic                  w_load;
    logic                  w_last;
    logic [CW-1:0]         w_blk_last;
    logic [CNT_W-1:0]      w_frame_cnt_nxt;
    logic [HDR_BITS-1:0]   w_hdr_image;

    assign w_rd       = (r_state == PAYLOAD);
    assign w_rd_bit   = r_mem[r_rptr];
    assign w_full     = (r_level == LVL_FULL);
    assign w_wr       = bit_valid & (~w_full | w_rd);
    assign w_drop     = bit_valid & w_full & ~w_rd;
    // On the last payload cycle the start test must see the level after this cycle's pop.
    assign w_lvl_eval = w_rd ? (r_level - LVL_W'(1)) : r_level;
    assign w_bs_ok    = (block_size != {CNT_W{1'b0}}) && (CMP_W'(block_size) <= DEPTH_C);
    assign w_start_ok = enable && w_bs_ok && (CMP_W'(w_lvl_eval) >= CMP_W'(block_size));
    assign w_blk_last = CW'(r_blk) - CW'(1);
    assign w_frame_cnt_nxt = w_last ? (r_frame_cnt + CNT_W'(1)) : r_frame_cnt;

`ifdef DQM_FRAME_COUNT_EN
    assign w_hdr_image = {r_stage, WORD_W'(w_frame_cnt_nxt)};
`else
    assign w_hdr_image = r_stage;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and frame-boundary strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = HDR;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            HDR: begin
                if (r_bit_cnt == HDR_LAST) begin
                    w_state_nxt = PAYLOAD;
                end else begin
                    w_state_nxt = HDR;
                end
            end
            PAYLOAD: begin
                if (r_bit_cnt == w_blk_last) begin
                    w_last = 1'b1;
                    if (w_start_ok) begin
                        w_state_nxt = HDR;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = PAYLOAD;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Header shift register, bit counter and latched block size.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= {HDR_BITS{1'b0}};
            r_bit_cnt <= {CW{1'b0}};
            r_blk     <= {CNT_W{1'b0}};
        end else if (w_load) begin
            r_shift   <= w_hdr_image;
            r_bit_cnt <= {CW{1'b0}};
            r_blk     <= block_size;
        end else if (r_state == HDR) begin
            r_shift   <= {r_shift[HDR_BITS-2:0], 1'b0};
            r_bit_cnt <= (r_bit_cnt == HDR_LAST) ? {CW{1'b0}} : (r_bit_cnt + CW'(1));
        end else if (r_state == PAYLOAD) begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
        end else begin
            r_bit_cnt <= r_bit_cnt;
        end
    end

    // Payload FIFO storage, pointers and fill level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem   <= {FIFO_DEPTH{1'b0}};
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_level <= {LVL_W{1'b0}};
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= bit_in;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Header staging, frame counter and sticky overflow (a drop beats a clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage     <= {STG_W{1'b0}};
            r_frame_cnt <= {CNT_W{1'b0}};
            r_overflow  <= 1'b0;
        end else begin
            if (hdr_load) begin
                r_stage <= hdr_words;
            end
            r_frame_cnt <= w_frame_cnt_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Registered serial outputs, one cycle behind the FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_serial_out   <= 1'b0;
            r_serial_valid <= 1'b0;
            r_interrupt    <= 1'b0;
        end else begin
            case (r_state)
                HDR: begin
                    r_serial_out   <= r_shift[HDR_BITS-1];
                    r_serial_valid <= 1'b1;
                    r_interrupt    <= 1'b0;
                end
                PAYLOAD: begin
                    r_serial_out   <= w_rd_bit;
                    r_serial_valid <= 1'b1;
                    r_interrupt    <= (r_bit_cnt == {CW{1'b0}});
                end
                default: begin
                    r_serial_out   <= 1'b0;
                    r_serial_valid <= 1'b0;
                    r_interrupt    <= 1'b0;
                end
            endcase
        end
    end

    assign serial_out   = r_serial_out;
    assign serial_valid = r_serial_valid;
    assign interrupt    = r_interrupt;
    assign frame_cnt    = r_frame_cnt;
    assign overflow     = r_overflow;
    assign fifo_level   = r_level;

endmodule

// File: tb/tb_dqm_framer.sv
// Self-checking bench for dqm_framer: stream-level scoreboard, a legality table and directed corner sequences.
module tb_dqm_framer;
    localparam int FIFO_DEPTH = 64;
`ifdef DQM_FRAME_COUNT_EN
    localparam int HB = 64;
`else
    localparam int HB = 48;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic [47:0] hdr_words = 48'h0;
    logic        hdr_load = 1'b0;
    logic [15:0] block_size = 16'd0;
    logic        enable = 1'b0;
    logic        clear_overflow = 1'b0;
    logic        serial_out, serial_valid, interrupt, overflow;
    logic [15:0] frame_cnt;
    logic [6:0]  fifo_level;

    int n_checks = 0;
    int n_err = 0;

    dqm_framer dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .hdr_words(hdr_words), .hdr_load(hdr_load), .block_size(block_size),
        .enable(enable), .clear_overflow(clear_overflow),
        .serial_out(serial_out), .serial_valid(serial_valid), .interrupt(interrupt),
        .frame_cnt(frame_cnt), .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: queue of buffered bits + queue of pending frame bits
    typedef struct packed {
        logic b;
        logic pay;
        logic first;
        logic last;
    } item_t;

    logic        mq[$];
    item_t       oq[$];
    logic [47:0] m_stage = 48'h0;
    logic [15:0] m_cnt = 16'h0;
    logic        m_ovf = 1'b0;
    logic        e_out = 1'b0, e_val = 1'b0, e_int = 1'b0, e_ovf = 1'b0;
    logic [15:0] e_cnt = 16'h0;
    int          e_lvl = 0;
    bit          m_started = 1'b0;

    task automatic model_step();
        int lvl0, bs;
        bit popping, full, wr, drop, start;
        item_t it;
        logic [HB-1:0] img;
        m_started = 1'b1;
        if (rst) begin
            mq.delete(); oq.delete();
            m_stage = 48'h0; m_cnt = 16'h0; m_ovf = 1'b0;
            e_out = 1'b0; e_val = 1'b0; e_int = 1'b0; e_cnt = 16'h0; e_ovf = 1'b0; e_lvl = 0;
            return;
        end
        lvl0    = mq.size();
        popping = (oq.size() > 0) && oq[0].pay;
        full    = (lvl0 == FIFO_DEPTH);
        wr      = bit_valid && (!full || popping);
        drop    = bit_valid && full && !popping;
        bs      = int'(block_size);
        start   = (oq.size() <= 1) && enable && (bs != 0) && (bs <= FIFO_DEPTH)
                  && ((lvl0 - (popping ? 1 : 0)) >= bs);
        e_val = 1'b0; e_out = 1'b0; e_int = 1'b0;
        if (oq.size() > 0) begin
            it = oq.pop_front();
            e_val = 1'b1; e_out = it.b; e_int = it.first;
            if (it.pay) void'(mq.pop_front());
            if (it.last) m_cnt = m_cnt + 16'd1;
        end
        if (start) begin
`ifdef DQM_FRAME_COUNT_EN
            img = {m_stage, m_cnt};
`else
            img = m_stage;
`endif
            for (int i = HB - 1; i >= 0; i--) begin
                it.b = img[i]; it.pay = 1'b0; it.first = 1'b0; it.last = 1'b0;
                oq.push_back(it);
            end
            for (int i = 0; i < bs; i++) begin
                it.b = mq[i]; it.pay = 1'b1; it.first = (i == 0); it.last = (i == bs - 1);
                oq.push_back(it);
            end
        end
        if (wr) mq.push_back(bit_in);
        if (drop) m_ovf = 1'b1;
        else if (clear_overflow) m_ovf = 1'b0;
        if (hdr_load) m_stage = hdr_words;
        e_cnt = m_cnt; e_ovf = m_ovf; e_lvl = mq.size();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_started) begin
                check("sb_serial_out", 64'(serial_out), 64'(e_out));
                check("sb_serial_valid", 64'(serial_valid), 64'(e_val));
                check("sb_interrupt", 64'(interrupt), 64'(e_int));
                check("sb_frame_cnt", 64'(frame_cnt), 64'(e_cnt));
                check("sb_overflow", 64'(overflow), 64'(e_ovf));
                check("sb_fifo_level", 64'(fifo_level), 64'(e_lvl));
            end
        end
    end

    // ---------------- stimulus helpers
    logic cap[0:511];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bit_valid = 1'b0; hdr_load = 1'b0; enable = 1'b0; clear_overflow = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // mode 0: alternating 1,0,1,0...; mode 1: random bits
    task automatic write_bits(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            bit_in    = (mode == 0) ? ((i % 2) == 0) : 1'($urandom_range(0, 1));
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic collect(input int n, input int budget, output int got, output int int_idx, output bit contig);
        int first_c, last_c;
        first_c = -1; last_c = -1; got = 0; int_idx = -1;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            if (serial_valid) begin
                cap[got] = serial_out;
                if (interrupt && int_idx < 0) int_idx = got;
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
        end
        contig = (got > 0) && (last_c - first_c + 1 == got);
        tick();
    endtask

    task automatic count_valid(input int cycles, output int nv);
        nv = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (serial_valid) nv++;
        end
        tick();
    endtask

    function automatic logic [63:0] cap_word(input int start, input int len);
        logic [63:0] v;
        v = 64'h0;
        for (int i = 0; i < len; i++) v = {v[62:0], cap[start + i]};
        return v;
    endfunction

    function automatic logic [63:0] hdr_image(input logic [47:0] h, input logic [15:0] cnt);
`ifdef DQM_FRAME_COUNT_EN
        return {h, cnt};
`else
        return 64'(h) | (64'(cnt) & 64'h0);
`endif
    endfunction

    typedef struct {
        int bs;
        int nbits;
        bit en;
        int exp_lvl;
        int exp_valid;
    } vec_t;

    initial begin
        vec_t tbl[8];
        int got, iidx, nv, lc, vc, gaps;
        bit contig;

        tbl[0] = '{16, 16, 1'b1, 16, HB + 16};
        tbl[1] = '{32, 31, 1'b1, 31, 0};
        tbl[2] = '{0, 10, 1'b1, 10, 0};
        tbl[3] = '{65, 64, 1'b1, 64, 0};
        tbl[4] = '{64, 64, 1'b1, 64, HB + 64};
        tbl[5] = '{8, 8, 1'b0, 8, 0};
        tbl[6] = '{1, 1, 1'b1, 1, HB + 1};
        tbl[7] = '{8, 70, 1'b0, 64, 0};

        // reset state
        tick();
        do_reset();
        @(negedge clk);
        check("rst_serial_valid", 64'(serial_valid), 64'h0);
        check("rst_serial_out", 64'(serial_out), 64'h0);
        check("rst_interrupt", 64'(interrupt), 64'h0);
        check("rst_overflow", 64'(overflow), 64'h0);
        check("rst_fifo_level", 64'(fifo_level), 64'h0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'h0);
        tick();

        // block_size legality / fill table
        for (int t = 0; t < 8; t++) begin
            do_reset();
            block_size = 16'(tbl[t].bs);
            write_bits(tbl[t].nbits, 1);
            @(negedge clk);
            check($sformatf("tbl%0d_level", t), 64'(fifo_level), 64'(tbl[t].exp_lvl));
            tick();
            enable = tbl[t].en;
            count_valid(200, nv);
            check($sformatf("tbl%0d_valid_cycles", t), 64'(nv), 64'(tbl[t].exp_valid));
            enable = 1'b0;
        end

        // basic frame
        do_reset();
        hdr_words = 48'hA5A5_1234_FFFF; hdr_load = 1'b1;
        tick();
        hdr_load = 1'b0; block_size = 16'd16; enable = 1'b1;
        write_bits(16, 0);
        collect(HB + 16, 300, got, iidx, contig);
        check("basic_len", 64'(got), 64'(HB + 16));
        check("basic_contig", 64'(contig), 64'h1);
        check("basic_hdr", cap_word(0, HB), hdr_image(48'hA5A5_1234_FFFF, 16'h0));
        check("basic_payload", cap_word(HB, 16), 64'hAAAA);
        check("basic_irq_idx", 64'(iidx), 64'(HB));
        @(negedge clk);
        check("basic_frame_cnt", 64'(frame_cnt), 64'h1);
        tick();
        enable = 1'b0;

        // no underflow
        do_reset();
        block_size = 16'd32; enable = 1'b1;
        write_bits(31, 1);
        count_valid(20, nv);
        check("nounder_idle", 64'(nv), 64'h0);
        write_bits(1, 1);
        lc = -1; vc = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (fifo_level == 7'd32 && lc < 0) lc = c;
            if (serial_valid && vc < 0) vc = c;
        end
        check("nounder_latency", 64'(vc - lc), 64'h2);
        tick();
        enable = 1'b0;
        count_valid(100, nv);

        // overflow
        do_reset();
        block_size = 16'd16;
        write_bits(70, 1);
        @(negedge clk);
        check("ovf_level", 64'(fifo_level), 64'd64);
        check("ovf_set", 64'(overflow), 64'h1);
        tick();
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 64'(overflow), 64'h0);
        tick();
        clear_overflow = 1'b1; bit_valid = 1'b1;
        tick();
        clear_overflow = 1'b0; bit_valid = 1'b0;
        @(negedge clk);
        check("ovf_set_wins", 64'(overflow), 64'h1);
        tick();

        // back-to-back frames
        do_reset();
        block_size = 16'd8; enable = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
        vc = -1;
        for (int c = 0; c < 50 && vc < 0; c++) begin
            @(negedge clk);
            if (serial_valid) vc = c;
        end
        check("b2b_started", 64'(vc >= 0), 64'h1);
        gaps = 0;
        for (int k = 0; k < 3 * (HB + 8); k++) begin
            if (k > 0) @(negedge clk);
            if (!serial_valid) gaps++;
            if (k == 0) check("b2b_cnt0", 64'(frame_cnt), 64'h0);
            if (((k + 1) % (HB + 8)) == 0)
                check($sformatf("b2b_cnt%0d", (k + 1) / (HB + 8)), 64'(frame_cnt), 64'((k + 1) / (HB + 8)));
        end
        check("b2b_gaps", 64'(gaps), 64'h0);
        tick();
        bit_valid = 1'b0; enable = 1'b0;
        count_valid(100, nv);

        // header load coincident with frame start
        do_reset();
        hdr_words = 48'h1111_2222_3333; hdr_load = 1'b1;
        tick();
        hdr_load = 1'b0; block_size = 16'd4;
        write_bits(8, 1);
        hdr_words = 48'hDEAD_BEEF_0F0F; hdr_load = 1'b1; enable = 1'b1;
        tick();
        hdr_load = 1'b0;
        collect(2 * (HB + 4), 400, got, iidx, contig);
        check("hdrupd_len", 64'(got), 64'(2 * (HB + 4)));
        check("hdrupd_contig", 64'(contig), 64'h1);
        check("hdrupd_old", cap_word(0, HB), hdr_image(48'h1111_2222_3333, 16'h0));
        check("hdrupd_new", cap_word(HB + 4, HB), hdr_image(48'hDEAD_BEEF_0F0F, 16'h1));
        enable = 1'b0;

        // reset mid-payload
        do_reset();
        hdr_words = 48'h0123_4567_89AB; hdr_load = 1'b1;
        tick();
        hdr_load = 1'b0; block_size = 16'd16; enable = 1'b1;
        write_bits(20, 1);
        vc = -1;
        for (int c = 0; c < 200 && vc < 0; c++) begin
            @(negedge clk);
            if (interrupt) vc = c;
        end
        check("rstmid_reached_payload", 64'(vc >= 0), 64'h1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_valid", 64'(serial_valid), 64'h0);
        check("rstmid_out", 64'(serial_out), 64'h0);
        check("rstmid_irq", 64'(interrupt), 64'h0);
        check("rstmid_level", 64'(fifo_level), 64'h0);
        check("rstmid_cnt", 64'(frame_cnt), 64'h0);
        tick();
        count_valid(20, nv);
        check("rstmid_no_tail", 64'(nv), 64'h0);
        write_bits(16, 1);
        collect(HB + 16, 300, got, iidx, contig);
        check("rstmid_next_len", 64'(got), 64'(HB + 16));
        check("rstmid_next_hdr", cap_word(0, HB), hdr_image(48'h0, 16'h0));
        enable = 1'b0;

        // randomized traffic against the scoreboard
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit_valid      = ($urandom_range(0, 99) < 70);
            bit_in         = 1'($urandom_range(0, 1));
            enable         = ($urandom_range(0, 99) < 90);
            hdr_load       = ($urandom_range(0, 99) < 5);
            hdr_words      = {$urandom, 16'($urandom)};
            clear_overflow = ($urandom_range(0, 99) < 5);
            rst            = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 3))
                    0:       block_size = 16'd0;
                    1:       block_size = 16'd65;
                    2:       block_size = 16'd64;
                    default: block_size = 16'($urandom_range(1, 20));
                endcase
            end
            tick();
        end
        rst = 1'b0; bit_valid = 1'b0; enable = 1'b0; hdr_load = 1'b0; clear_overflow = 1'b0;
        count_valid(150, nv);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
